// File: rtl/boot_sram_arb.sv
// boot_sram_arb: owns the single SRAM port and shares it between the boot-loader
// write stream and the CPU instruction-fetch bus.
//
// Boot writes cannot be back-pressured, so they are absorbed into a small FIFO and
// drained to SRAM one request at a time. The CPU is granted the port only once the
// FIFO has drained; load_done reports that the image is complete and the CPU owns
// the port. A boot write arriving while the CPU owns the port (a reboot) takes the
// port back, letting any in-flight CPU read finish first.
//
// Optional feature (macro BOOT_ARB_STATS_EN): adds output load_cnt, a saturating
// count of SRAM write acceptances since the last reboot or reset.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   boot_valid/addr/wdata/wstrb      boot write stream, one word per cycle, no ready
//   cpu_i_valid/addr                 CPU fetch request, held until cpu_i_ready
//   cpu_i_rdata, cpu_i_ready         registered fetch data and one-cycle completion pulse
//   sram_valid/addr/wdata/wstrb      SRAM request, held until sram_ready (wstrb 0 = read)
//   sram_rdata, sram_ready           SRAM read data and accept/complete
//   load_done                        boot image written and CPU granted
//   load_cnt                         write acceptances since reboot (BOOT_ARB_STATS_EN only)
//   ovf_err                          sticky boot FIFO overflow
module boot_sram_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                boot_valid,
    input  logic [ADDR_W-1:0]   boot_addr,
    input  logic [DATA_W-1:0]   boot_wdata,
    input  logic [DATA_W/8-1:0] boot_wstrb,
    input  logic                cpu_i_valid,
    input  logic [ADDR_W-1:0]   cpu_i_addr,
    output logic [DATA_W-1:0]   cpu_i_rdata,
    output logic                cpu_i_ready,
    output logic                sram_valid,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_wstrb,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_ready,
    output logic                load_done,
`ifdef BOOT_ARB_STATS_EN
    output logic [15:0]         load_cnt,
`endif
    output logic                ovf_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StFlush
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Boot write FIFO. Pointers carry a wrap bit so full and empty can be
    // told apart when the index bits match.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];
    logic [STRB_W-1:0] fifo_wstrb [DEPTH];

    logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW-1:0] wr_idx, rd_idx;
    logic               fifo_empty, fifo_full;
    logic               push, pop, drop;

    // Request register driving the SRAM port.
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [STRB_W-1:0] req_wstrb_q;
    logic              req_cpu_q;

    logic              req_done;
    logic              issue_wr, issue_rd;

    logic              load_done_q, load_done_d;
    logic              ovf_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rready_q;

    assign wr_idx     = wr_ptr_q[FIFO_AW-1:0];
    assign rd_idx     = rd_ptr_q[FIFO_AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign req_done = req_valid_q && sram_ready;

    // The head entry stays in the FIFO while its request is outstanding and is
    // retired only when the SRAM accepts it.
    assign pop  = req_done && !req_cpu_q;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign push = boot_valid && (!fifo_full || pop);
    assign drop = boot_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx]  <= boot_addr;
            fifo_wdata[wr_idx] <= boot_wdata;
            fifo_wstrb[wr_idx] <= boot_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        load_done_d = load_done_q;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (!req_valid_q) begin
                    if (!fifo_empty) begin
                        issue_wr = 1'b1;
                    end else if (!boot_valid) begin
                        state_d     = StRun;
                        load_done_d = 1'b1;
                    end
                end
            end

            StRun: begin
                if (boot_valid) begin
                    // Reboot: a read completing this very edge needs no flush.
                    load_done_d = 1'b0;
                    state_d     = (req_valid_q && !sram_ready) ? StFlush : StLoad;
                end else if (cpu_i_valid && !req_valid_q && !rready_q) begin
                    // rready_q high means the CPU is still holding the request it
                    // just had answered; do not fetch it twice.
                    issue_rd = 1'b1;
                end
            end

            StFlush: begin
                if (!req_valid_q || sram_ready) begin
                    state_d = StLoad;
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM request register. Issue only ever happens with no request
    // outstanding, so the next request follows acceptance by one idle cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_cpu_q   <= 1'b0;
        end else if (req_done) begin
            req_valid_q <= 1'b0;
        end else if (issue_wr) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= fifo_addr[rd_idx];
            req_wdata_q <= fifo_wdata[rd_idx];
            req_wstrb_q <= fifo_wstrb[rd_idx];
            req_cpu_q   <= 1'b0;
        end else if (issue_rd) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= cpu_i_addr;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_cpu_q   <= 1'b1;
        end
    end

    // Fetch response: registered data and a one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rready_q <= 1'b0;
        end else begin
            rready_q <= req_done && req_cpu_q;
            if (req_done && req_cpu_q) begin
                rdata_q <= sram_rdata;
            end
        end
    end

`ifdef BOOT_ARB_STATS_EN
    logic [15:0] load_cnt_q;

    // Restarts whenever the CPU loses the port to a reboot; no writes happen in
    // RUN so the value naturally holds there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q <= '0;
        end else if (state_q == StRun && state_d != StRun) begin
            load_cnt_q <= '0;
        end else if (pop && load_cnt_q != 16'hFFFF) begin
            load_cnt_q <= load_cnt_q + 16'd1;
        end
    end

    assign load_cnt = load_cnt_q;
`endif

    assign sram_valid  = req_valid_q;
    assign sram_addr   = req_addr_q;
    assign sram_wdata  = req_wdata_q;
    assign sram_wstrb  = req_wstrb_q;
    assign cpu_i_rdata = rdata_q;
    assign cpu_i_ready = rready_q;
    assign load_done   = load_done_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_boot_sram_arb.sv
`timescale 1ns/1ps
module tb_boot_sram_arb;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_valid;
    logic [31:0] boot_addr;
    logic [31:0] boot_wdata;
    logic [3:0]  boot_wstrb;
    logic        cpu_i_valid;
    logic [31:0] cpu_i_addr;
    logic [31:0] cpu_i_rdata;
    logic        cpu_i_ready;
    logic        sram_valid;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic        load_done;
    logic        ovf_err;
`ifdef BOOT_ARB_STATS_EN
    logic [15:0] load_cnt;
`endif

    boot_sram_arb #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .FIFO_AW (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boot_valid  (boot_valid),
        .boot_addr   (boot_addr),
        .boot_wdata  (boot_wdata),
        .boot_wstrb  (boot_wstrb),
        .cpu_i_valid (cpu_i_valid),
        .cpu_i_addr  (cpu_i_addr),
        .cpu_i_rdata (cpu_i_rdata),
        .cpu_i_ready (cpu_i_ready),
        .sram_valid  (sram_valid),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_wstrb  (sram_wstrb),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready),
        .load_done   (load_done),
`ifdef BOOT_ARB_STATS_EN
        .load_cnt    (load_cnt),
`endif
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    int unsigned num_checks = 0;
    int unsigned num_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got === exp) num_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of boot writes the arbiter still owes the
    // SRAM (bounded by the FIFO depth), the memory image those writes
    // should produce, and the sticky overflow flag.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] model_mem [16];
    logic [31:0] sram_mem  [16];
    bit          exp_ovf   = 1'b0;
    bit          exp_rdy   = 1'b0;
    logic [31:0] exp_rdata = '0;
    int unsigned wr_acc_cnt = 0;

    bit          prev_pend = 1'b0;
    bit          prev_acc  = 1'b0;
    bit          prev_wacc = 1'b0;
    bit          prev_boot = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_strb;
    wr_t         mon_e;
    bit          mon_acc, mon_wacc, mon_racc, mon_full;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign sram_rdata = sram_mem[sram_addr[5:2]];

    // Monitor: samples on the falling edge what the next rising edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_rdy   = 1'b0;
            prev_pend = 1'b0;
            prev_acc  = 1'b0;
            prev_wacc = 1'b0;
            prev_boot = 1'b0;
        end else begin
            check_eq("ovf_err", ovf_err, exp_ovf);
            if (cpu_i_ready || exp_rdy) begin
                check_eq("cpu_i_ready", cpu_i_ready, exp_rdy);
                if (exp_rdy) check_eq("cpu_i_rdata", cpu_i_rdata, exp_rdata);
            end
            if (prev_boot) check_eq("load_done_after_boot", load_done, 1'b0);
            if (prev_wacc) check_eq("load_done_after_write", load_done, 1'b0);
            if (prev_acc) check_eq("gap_after_accept", sram_valid, 1'b0);
            if (prev_pend) begin
                check_eq("req_held", {sram_valid, sram_addr, sram_wdata, sram_wstrb},
                         {1'b1, prev_addr, prev_wdata, prev_strb});
            end else if (sram_valid && sram_wstrb == 4'd0) begin
                // A fresh read: the boot image must be complete and the CPU owning the port.
                check_eq("rd_only_when_loaded", {load_done, exp_q.size() == 0}, 2'b11);
                check_eq("rd_addr", {cpu_i_valid, sram_addr}, {1'b1, cpu_i_addr});
            end

            mon_acc  = sram_valid && sram_ready;
            mon_wacc = mon_acc && (sram_wstrb != 4'd0);
            mon_racc = mon_acc && (sram_wstrb == 4'd0);
            mon_full = (exp_q.size() == DEPTH);

            if (mon_wacc) begin
                check_eq("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("wr_addr", sram_addr, mon_e.addr);
                    check_eq("wr_data", sram_wdata, mon_e.data);
                    check_eq("wr_strb", sram_wstrb, mon_e.strb);
                    model_mem[mon_e.addr[5:2]] = merge(model_mem[mon_e.addr[5:2]],
                                                       mon_e.data, mon_e.strb);
                end
                sram_mem[sram_addr[5:2]] = merge(sram_mem[sram_addr[5:2]], sram_wdata,
                                                 sram_wstrb);
                wr_acc_cnt++;
            end
            exp_rdy = mon_racc;
            if (mon_racc) exp_rdata = model_mem[sram_addr[5:2]];

            if (boot_valid) begin
                if (mon_full && !mon_wacc) exp_ovf = 1'b1;
                else exp_q.push_back('{addr: boot_addr, data: boot_wdata, strb: boot_wstrb});
            end

            prev_pend  = sram_valid && !sram_ready;
            prev_acc   = mon_acc;
            prev_wacc  = mon_wacc;
            prev_boot  = boot_valid;
            prev_addr  = sram_addr;
            prev_wdata = sram_wdata;
            prev_strb  = sram_wstrb;
        end
    end

    // SRAM acceptance driver.
    int unsigned ready_pct = 100;
    initial begin
        sram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sram_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // CPU fetch driver: holds each request until cpu_i_ready.
    bit          cpu_en    = 1'b0;
    bit          cpu_fixed = 1'b0;
    logic [31:0] cpu_fixed_addr = '0;
    initial begin
        cpu_i_valid = 1'b0;
        cpu_i_addr  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cpu_i_valid) begin
                if (cpu_i_ready) cpu_i_valid = 1'b0;
            end else if (cpu_en && (cpu_fixed || $urandom_range(3) == 0)) begin
                cpu_i_valid = 1'b1;
                cpu_i_addr  = cpu_fixed ? cpu_fixed_addr
                                        : {26'd0, 4'($urandom_range(15)), 2'b00};
            end
        end
    end

    task automatic boot_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk);
        #1;
        boot_valid = 1'b1;
        boot_addr  = a;
        boot_wdata = d;
        boot_wstrb = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            boot_valid = 1'b0;
        end
    endtask

    task automatic wait_load_done(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, load_done, 1'b1);
    endtask

    task automatic wait_cpu_ready(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_i_ready && n < 300);
        check_eq(tag, cpu_i_ready, 1'b1);
    endtask

    task automatic wait_rd_req(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sram_valid && sram_wstrb == 4'd0) && n < 100);
        check_eq(tag, sram_valid, 1'b1);
    endtask

    int unsigned base;

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = '0;
            sram_mem[i]  = '0;
        end
        boot_valid = 1'b0;
        boot_addr  = '0;
        boot_wdata = '0;
        boot_wstrb = '0;
        rst_n      = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_sram", {sram_valid, sram_addr, sram_wdata, sram_wstrb}, '0);
        check_eq("rst_cpu", {cpu_i_ready, cpu_i_rdata}, '0);
        check_eq("rst_flags", {load_done, ovf_err}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Eight boot writes, paced at the one-write-per-two-cycles SRAM rate so
        // the 4-deep FIFO never overflows.
        base = wr_acc_cnt;
        for (int i = 0; i < 8; i++) begin
            boot_push(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            idle(1);
        end
        wait_load_done("t1_load_done");
        check_eq("t1_writes", wr_acc_cnt - base, 8);
        check_eq("t1_ovf", ovf_err, 1'b0);
        for (int i = 0; i < 8; i++) check_eq("t1_mem", sram_mem[i], 32'hA0 + 32'(i));
`ifdef BOOT_ARB_STATS_EN
        check_eq("t1_load_cnt", load_cnt, 16'd8);
`endif

        // Stalled SRAM during a back-to-back burst: only the first four survive.
        ready_pct = 0;
        idle(2);
        base = wr_acc_cnt;
        for (int i = 0; i < 8; i++) boot_push(32'(i * 4), 32'hB0 + 32'(i), 4'hF);
        idle(2);
        ready_pct = 100;
        wait_load_done("t2_load_done");
        check_eq("t2_writes", wr_acc_cnt - base, 4);
        check_eq("t2_ovf", ovf_err, 1'b1);
        for (int i = 0; i < 4; i++) check_eq("t2_kept", sram_mem[i], 32'hB0 + 32'(i));
        for (int i = 4; i < 8; i++) check_eq("t2_dropped", sram_mem[i], 32'hA0 + 32'(i));
`ifdef BOOT_ARB_STATS_EN
        check_eq("t2_load_cnt", load_cnt, 16'd4);
`endif

        // Single fetch from 0x4 after load.
        boot_push(32'h4, 32'h1234_5678, 4'hF);
        idle(1);
        wait_load_done("t3_load_done");
        ready_pct      = 0;
        cpu_fixed      = 1'b1;
        cpu_fixed_addr = 32'h4;
        cpu_en         = 1'b1;
        wait_rd_req("t3_rd_req");
        cpu_en = 1'b0;
        check_eq("t3_rd_req_fields", {sram_addr, sram_wstrb}, {32'h4, 4'h0});
        ready_pct = 100;
        wait_cpu_ready("t3_ready");
        check_eq("t3_rdata", cpu_i_rdata, 32'h1234_5678);
        @(negedge clk);
        check_eq("t3_ready_pulse", cpu_i_ready, 1'b0);

        // Fetch requested while still loading: held off until the image is in.
        ready_pct = 0;
        idle(2);
        boot_push(32'h20, 32'hD0, 4'hF);
        boot_push(32'h24, 32'hD1, 4'h3);
        idle(1);
        cpu_fixed_addr = 32'h24;
        cpu_en         = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("t4_no_read", sram_valid && sram_wstrb == 4'd0, 1'b0);
            check_eq("t4_no_ready", cpu_i_ready, 1'b0);
        end
        ready_pct = 100;
        wait_cpu_ready("t4_ready");
        cpu_en = 1'b0;
        check_eq("t4_loaded", load_done, 1'b1);
        check_eq("t4_rdata", cpu_i_rdata, 32'h0000_00D1);

        // Reboot while a fetch is stalled: fetch completes, then the write drains.
        idle(2);
        ready_pct      = 0;
        cpu_fixed_addr = 32'h8;
        cpu_en         = 1'b1;
        wait_rd_req("t5_rd_req");
        cpu_en = 1'b0;
        boot_push(32'h10, 32'hC5, 4'hF);
        idle(1);
        @(negedge clk);
        check_eq("t5_load_done_fell", load_done, 1'b0);
        check_eq("t5_read_kept", {sram_valid, sram_wstrb}, {1'b1, 4'h0});
        ready_pct = 100;
        wait_cpu_ready("t5_ready");
        check_eq("t5_rdata", cpu_i_rdata, 32'hB2);
        wait_load_done("t5_reload");
        check_eq("t5_written", sram_mem[4], 32'hC5);
        check_eq("t5_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stalled burst.
        ready_pct = 0;
        idle(2);
        for (int i = 0; i < 3; i++) boot_push(32'h30 + 32'(i * 4), 32'hE0 + 32'(i), 4'hF);
        idle(1);
        @(negedge clk);
        check_eq("t6_busy", {sram_valid, ovf_err}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_rst", {sram_valid, load_done, ovf_err}, 3'b000);
        ready_pct = 100;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_load_done("t6_after_rst");

        // Randomized traffic against the model.
        cpu_fixed = 1'b0;
        cpu_en    = 1'b1;
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(2))
                0: ready_pct = 30;
                1: ready_pct = 70;
                default: ready_pct = 100;
            endcase
            if ($urandom_range(2) == 0) begin
                for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
                    boot_push({26'd0, 4'($urandom_range(15)), 2'b00}, $urandom,
                              4'($urandom_range(15, 1)));
                    if ($urandom_range(1) == 0) idle(1);
                end
            end
            idle($urandom_range(12, 1));
        end

        cpu_en    = 1'b0;
        ready_pct = 100;
        idle(2);
        wait_load_done("final_load_done");
        repeat (20) @(negedge clk);
        check_eq("final_cpu_idle", cpu_i_valid, 1'b0);
        check_eq("final_drained", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) check_eq("final_image", sram_mem[i], model_mem[i]);

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule

// File: doc/boot_sram_arb.md
Name: boot_sram_arb

Overview:
- Downstream of the boot controller. Owns the single SRAM port and arbitrates it between two sources: the boot-loader write stream and the CPU instruction-fetch bus.
- The boot stream cannot be back-pressured, so its writes are absorbed in an internal FIFO and drained to SRAM as the SRAM accepts them.
- The CPU is granted the port only after the FIFO is empty. `load_done` reports that the SRAM image is complete.

Parameters:
- ADDR_W, 32, SRAM byte-address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- FIFO_AW, 2, log2 of boot write FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- boot_valid  in  1  boot write request, one word per cycle, no ready.
- boot_addr  in  ADDR_W  boot write byte address.
- boot_wdata  in  DATA_W  boot write data.
- boot_wstrb  in  DATA_W/8  boot write strobes.
- cpu_i_valid  in  1  CPU fetch request.
- cpu_i_addr  in  ADDR_W  CPU fetch byte address.
- cpu_i_rdata  out  DATA_W  fetch data (registered).
- cpu_i_ready  out  1  one-cycle fetch completion pulse.
- sram_valid  out  1  SRAM request.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_wstrb  out  DATA_W/8  SRAM strobes; 0 means read.
- sram_rdata  in  DATA_W  SRAM read data, valid with sram_ready.
- sram_ready  in  1  SRAM accept/complete.
- load_done  out  1  boot image fully written and CPU granted.
- ovf_err  out  1  sticky FIFO overflow flag.

Behaviour:
- Reset values (asynchronous on rst_n low): state=LOAD, FIFO empty, all sram_* outputs 0, cpu_i_ready=0, cpu_i_rdata=0, load_done=0, ovf_err=0.
- FIFO write:
  - A boot_valid cycle pushes {boot_addr, boot_wdata, boot_wstrb} in the same clock edge, in any state.
  - Pointers are FIFO_AW+1 bits with wrap bit; full/empty are derived from them.
  - Push and pop in the same cycle are allowed when not empty; occupancy is unchanged.
  - Push while full and no pop: entry is dropped, ovf_err is set (sticky until reset).
- SRAM handshake:
  - A request holds sram_valid/addr/wdata/wstrb stable until sram_ready.
  - Transfer occurs on sram_valid && sram_ready.
  - sram_valid is registered. The next request may issue in the cycle after acceptance, giving one write per 2 cycles minimum.
- States:
  - LOAD:
    - If FIFO is not empty and no request is pending, issue the head entry and pop it on acceptance.
    - When FIFO is empty, no request is pending and boot_valid=0, go to RUN and set load_done=1.
    - CPU requests are ignored (cpu_i_ready stays 0).
  - RUN:
    - cpu_i_valid with no pending request issues a read (wstrb=0).
    - On sram_ready: register cpu_i_rdata<=sram_rdata and pulse cpu_i_ready for 1 cycle. Fetch latency is ≥2 cycles.
    - boot_valid (reboot) clears load_done the same edge. Go to LOAD if no CPU read is pending, else go to FLUSH.
  - FLUSH:
    - Wait for the pending CPU read to complete; still return its data via cpu_i_ready.
    - Then go to LOAD.
    - Boot pushes keep entering the FIFO throughout.
- Priority: boot writes always preempt new CPU reads. An in-flight CPU read is never aborted.
- cpu_i_valid must be held by the CPU until cpu_i_ready; no new CPU request is accepted in the cycle cpu_i_ready pulses.
- Address is passed unmodified; alignment is the source's responsibility.
- Reset mid-transfer: all state is dropped immediately; sram_valid is 0 asynchronously.

Optional Feature:
- Macro: BOOT_ARB_STATS_EN.
- Defined: adds output load_cnt [15:0].
  - Counts SRAM write acceptances since the last entry into LOAD from RUN, or since reset.
  - Saturates at 16'hFFFF; holds its value in RUN.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Reset, sram_ready tied 1, 8 consecutive boot writes to addrs 0x0..0x1C with data 0xA0..0xA7 -> 8 SRAM writes in order with matching addr/data, wstrb=4'hF.
  - load_done rises after the last write is accepted and boot_valid is low.
  - ovf_err=0. load_cnt=8 if BOOT_ARB_STATS_EN.
- Same as above but sram_ready low for 10 cycles during the burst, FIFO_AW=2 -> first 4 entries retained, later pushes dropped, ovf_err=1 and stays 1.
- After load_done, cpu_i_valid at addr 0x4 with sram_rdata=0x1234_5678 and sram_ready one cycle after request -> cpu_i_rdata=0x12345678, single-cycle cpu_i_ready, SRAM request carries wstrb=0.
- cpu_i_valid asserted during LOAD -> no SRAM read issued and cpu_i_ready stays 0 until all boot writes are drained and load_done=1.
- In RUN with a CPU read pending (sram_ready held low), boot_valid pulses -> load_done falls next edge, state goes to FLUSH.
  - The CPU read completes with its data.
  - The boot write issues afterwards; load_done returns to 1.
- rst_n asserted low mid-burst with sram_valid=1 -> sram_valid=0, load_done=0, ovf_err=0 immediately, without a clock edge.
